session_timer: RTL and testbench
================================

Name: session_timer

Overview:
- Parametrised successor of the fixed 4-minute experiment clock.
- Single-clock-domain seconds/minutes timer with programmable minute limit, count-up or count-down mode, pause/resume, and a sticky done flag.
- No derived clocks: all state advances on a one-cycle `tick` strobe from an internal prescaler.
- Feeds the display/LED logic (`sec`, `min`, `sec_led`) and the experiment sequencer (`done`, `running`).

Parameters:
- CYCLES_PER_SEC, 125000000, clk cycles per second; must be an even number ≥ 4.
- MIN_W, 6, width of the minute fields.
- DEFAULT_DOWN, 0, mode forced while in IDLE when `mode_sel_en`=0 (0 = up, 1 = down).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled each cycle; begins or resumes timing.
- stop  in  1  level-sampled each cycle; pauses timing.
- clear  in  1  level-sampled each cycle; aborts the run and returns to IDLE.
- mode_sel_en  in  1  1 = use `mode_down`; 0 = use DEFAULT_DOWN.
- mode_down  in  1  1 = count down from `limit_min`:00; 0 = count up to `limit_min`:00.
- limit_min  in  MIN_W  minute limit; latched on the IDLE→RUN transition.
- sec  out  6  seconds field, 0..59.
- min  out  MIN_W  minutes field.
- tick  out  1  one-cycle pulse per elapsed second while in RUN.
- sec_led  out  1  1 Hz square wave, 50% duty, in RUN only.
- running  out  1  high in RUN.
- done  out  1  sticky completion flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State enters IDLE.
  - Prescaler `div`=0.
  - `sec`=0, `min`=0, `tick`=0, `sec_led`=0, `running`=0, `done`=0.
  - Latched limit=0 and latched mode=0.
- States: IDLE, RUN, PAUSE, DONE. Control priority each cycle: clear > stop > start.
- IDLE:
  - `sec` and `min` are held at 0.
  - When start=1: latch `limit_min` and the effective mode, and go to RUN on the next edge.
  - In down mode, load `min`=limit and `sec`=0 on that same edge.
  - If the latched limit is 0, go directly to DONE with done=1; no tick is generated.
- RUN:
  - `div` counts 0..CYCLES_PER_SEC-1 and wraps.
  - When `div`==CYCLES_PER_SEC-1, `tick`=1 for exactly one cycle on the next edge, and the time fields update on the same edge.
  - `sec_led`=1 while `div` < CYCLES_PER_SEC/2, otherwise 0 (registered).
  - stop=1 → PAUSE. clear=1 → IDLE.
- Up count:
  - `sec` 59→0 with `min`+1; otherwise `sec`+1.
  - When the updated value equals limit:00, go to DONE.
- Down count:
  - `sec` 0→59 with `min`-1; otherwise `sec`-1.
  - When the updated value equals 0:00, go to DONE.
- Minute arithmetic is modulo 2^MIN_W. The limit check makes overflow unreachable.
- PAUSE:
  - `div`, `sec` and `min` hold. `sec_led`=0, `tick`=0.
  - start=1 (with stop=0) → RUN, resuming from the held `div` value (the partial second is preserved).
  - clear=1 → IDLE.
- DONE:
  - done=1. `sec` and `min` hold the final value (limit:00 for up, 0:00 for down).
  - `tick`=0, `sec_led`=0. start and stop are ignored.
  - Only clear=1 → IDLE with done=0, `sec`=`min`=0 and `div`=0.
- clear from any state: on the next edge `div`, `sec`, `min` and `done` are cleared and the state is IDLE.
- Simultaneous start and stop in IDLE or PAUSE: stop wins and there is no state change.
- `limit_min` and mode changes during RUN, PAUSE or DONE have no effect.
- `running`=1 iff state==RUN.
- Reset asserted mid-run aborts immediately with all outputs at their reset values.

Test Plan (CYCLES_PER_SEC=10, MIN_W=6):
- Up count: limit=2, pulse start.
  - First `tick` occurs 10 cycles after entering RUN.
  - `sec` reaches 59, then 0 with `min`=1.
  - After 120 ticks: `min`=2, `sec`=0, done=1, running=0, with no further ticks.
- Down count: mode_down=1, limit=1, start.
  - Time reads 1:00 immediately after start, then 0:59 after the first tick.
  - done=1 with 0:00 after 60 ticks.
- Pause/resume: stop at `div`=4 mid-second → fields and `div` frozen for 50 cycles.
  - After start, the next tick arrives 6 cycles later.
- clear: clear during RUN at 0:37 → IDLE, 0:00, done=0.
  - clear in DONE → done=0.
  - start in DONE without clear has no effect.
- Corner cases:
  - limit=0 with start → done=1 on the next edge, no tick.
  - start and stop together in IDLE → stays IDLE.
  - `sec_led` is high for 5 cycles and low for 5 cycles in RUN.
- Asynchronous reset pulse between clock edges during RUN → all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/session_timer_if.sv
// Control/status bundle for session_timer.
//   master (sequencer side): drives start/stop/clear/mode_sel_en/mode_down/limit_min,
//                            observes sec/min/tick/sec_led/running/done.
//   slave  (timer side):     the reverse.
interface session_timer_if #(
  parameter int MIN_W = 6
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             mode_sel_en;
  logic             mode_down;
  logic [MIN_W-1:0] limit_min;
  logic [5:0]       sec;
  logic [MIN_W-1:0] min;
  logic             tick;
  logic             sec_led;
  logic             running;
  logic             done;

  modport master (
    output start, stop, clear, mode_sel_en, mode_down, limit_min,
    input  sec, min, tick, sec_led, running, done
  );

  modport slave (
    input  start, stop, clear, mode_sel_en, mode_down, limit_min,
    output sec, min, tick, sec_led, running, done
  );
endinterface

// File: rtl/session_timer.sv
// Seconds/minutes session timer with programmable minute limit, up/down count,
// pause/resume and a sticky done state. Everything advances on an internal
// one-cycle tick produced by a free-running prescaler (no derived clocks).
// Ports:
//   clk  - system clock (rising edge)
//   rst  - asynchronous active-low reset
//   bus  - session_timer_if.slave: controls in, time fields / status out
module session_timer #(
  parameter int CYCLES_PER_SEC = 125000000,
  parameter int MIN_W          = 6,
  parameter bit DEFAULT_DOWN   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  session_timer_if.slave bus
);

  localparam int DIV_W = $clog2(CYCLES_PER_SEC);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CYCLES_PER_SEC - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CYCLES_PER_SEC / 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [MIN_W-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             sec_led_q, sec_led_d;

  // scratch for the next time value on a tick
  logic             eff_down;
  logic [5:0]       sec_n;
  logic [MIN_W-1:0] min_n;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sec_d     = sec_q;
    min_d     = min_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;
    eff_down  = bus.mode_sel_en ? bus.mode_down : DEFAULT_DOWN;
    sec_n     = sec_q;
    min_n     = min_q;

    case (state_q)
      S_IDLE: begin
        sec_d = '0;
        min_d = '0;
        div_d = '0;
        if (bus.start && !bus.stop) begin
          limit_d = bus.limit_min;
          mode_d  = eff_down;
          if (bus.limit_min == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            if (eff_down) min_d = bus.limit_min;
          end
        end
      end
      S_RUN: begin
        // stop freezes div in place so a later resume keeps the partial second
        if (bus.stop) begin
          state_d = S_PAUSE;
        end else if (div_q == DIV_MAX) begin
          div_d  = '0;
          tick_d = 1'b1;
          if (mode_q) begin
            if (sec_q == 6'd0) begin
              sec_n = 6'd59;
              min_n = min_q - 1'b1;
            end else begin
              sec_n = sec_q - 6'd1;
            end
          end else begin
            if (sec_q == 6'd59) begin
              sec_n = 6'd0;
              min_n = min_q + 1'b1;
            end else begin
              sec_n = sec_q + 6'd1;
            end
          end
          sec_d = sec_n;
          min_d = min_n;
          if (sec_n == 6'd0 && min_n == (mode_q ? '0 : limit_q)) state_d = S_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (bus.start && !bus.stop) state_d = S_RUN;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // clear beats everything, from any state
    if (bus.clear) begin
      state_d = S_IDLE;
      div_d   = '0;
      sec_d   = '0;
      min_d   = '0;
      tick_d  = 1'b0;
    end

    sec_led_d = (state_d == S_RUN) && (div_d < DIV_HALF);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      limit_q   <= '0;
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      sec_led_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      sec_led_q <= sec_led_d;
    end
  end

  assign bus.sec     = sec_q;
  assign bus.min     = min_q;
  assign bus.tick    = tick_q;
  assign bus.sec_led = sec_led_q;
  assign bus.running = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_session_timer.sv
module tb_session_timer;
  localparam int CPS   = 10;
  localparam int MIN_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  session_timer_if #(.MIN_W(MIN_W)) bus();

  session_timer #(.CYCLES_PER_SEC(CPS), .MIN_W(MIN_W), .DEFAULT_DOWN(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: elapsed whole seconds plus cycles into the current second.
  // Displayed time is derived arithmetically from elapsed seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_st, m_lim, m_down, m_el, m_ph, m_tick;

  task automatic model_reset();
    m_st = M_IDLE; m_lim = 0; m_down = 0; m_el = 0; m_ph = 0; m_tick = 0;
  endtask

  task automatic model_edge();
    int st_in;
    st_in  = m_st;
    m_tick = 0;
    if (st_in == M_IDLE) begin
      if (bus.start && !bus.stop) begin
        m_lim  = int'(bus.limit_min);
        m_down = bus.mode_sel_en ? int'(bus.mode_down) : 0;
        m_el   = 0;
        m_ph   = 0;
        m_st   = (m_lim == 0) ? M_DONE : M_RUN;
      end
    end else if (st_in == M_RUN) begin
      if (bus.stop) m_st = M_PAUSE;
      else begin
        m_ph++;
        if (m_ph == CPS) begin
          m_ph = 0;
          m_el++;
          m_tick = 1;
          if (m_el == m_lim * 60) m_st = M_DONE;
        end
      end
    end else if (st_in == M_PAUSE) begin
      if (bus.start && !bus.stop) m_st = M_RUN;
    end
    if (bus.clear) begin
      m_st = M_IDLE; m_el = 0; m_ph = 0; m_tick = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int t;
    t = (m_st == M_IDLE) ? 0 : (m_down != 0 ? m_lim * 60 - m_el : m_el);
    chk("sec",     32'(bus.sec),     32'(t % 60));
    chk("min",     32'(bus.min),     32'((t / 60) % (1 << MIN_W)));
    chk("tick",    32'(bus.tick),    32'(m_tick));
    chk("sec_led", 32'(bus.sec_led), 32'((m_st == M_RUN && m_ph < CPS / 2) ? 1 : 0));
    chk("running", 32'(bus.running), 32'(m_st == M_RUN ? 1 : 0));
    chk("done",    32'(bus.done),    32'(m_st == M_DONE ? 1 : 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sec"},     32'(bus.sec),     0);
    chk({tag, "_min"},     32'(bus.min),     0);
    chk({tag, "_tick"},    32'(bus.tick),    0);
    chk({tag, "_sec_led"}, 32'(bus.sec_led), 0);
    chk({tag, "_running"}, 32'(bus.running), 0);
    chk({tag, "_done"},    32'(bus.done),    0);
  endtask

  initial begin
    int cnt, led_cnt;
    rst = 1'b0;
    bus.start = 0; bus.stop = 0; bus.clear = 0;
    bus.mode_sel_en = 0; bus.mode_down = 0; bus.limit_min = '0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // up count to 2:00, first tick latency and LED duty
    bus.limit_min = 6'd2; bus.start = 1;
    step();
    bus.start = 0;
    cnt = 0; led_cnt = 0;
    while (!bus.tick && cnt < 20) begin
      step();
      cnt++;
      if (bus.sec_led) led_cnt++;
    end
    chk("first_tick_latency", cnt, CPS);
    chk("led_high_cycles", led_cnt, CPS / 2);
    cnt = 0;
    while (!bus.done && cnt < 1300) begin step(); cnt++; end
    chk("up_done", 32'(bus.done), 1);
    chk("up_min", 32'(bus.min), 2);
    chk("up_sec", 32'(bus.sec), 0);
    repeat (15) step();

    // start in DONE ignored, clear leaves DONE
    bus.start = 1; repeat (3) step(); bus.start = 0;
    chk("done_ignores_start", 32'(bus.done), 1);
    bus.clear = 1; step(); bus.clear = 0;
    chk("clear_done", 32'(bus.done), 0);

    // down count from 1:00
    bus.mode_sel_en = 1; bus.mode_down = 1; bus.limit_min = 6'd1; bus.start = 1;
    step();
    bus.start = 0; bus.mode_down = 0; bus.limit_min = 6'd5;
    chk("down_load_min", 32'(bus.min), 1);
    chk("down_load_sec", 32'(bus.sec), 0);
    repeat (CPS) step();
    chk("down_first_min", 32'(bus.min), 0);
    chk("down_first_sec", 32'(bus.sec), 59);
    cnt = 0;
    while (!bus.done && cnt < 700) begin step(); cnt++; end
    chk("down_done", 32'(bus.done), 1);
    chk("down_end_sec", 32'(bus.sec), 0);
    bus.clear = 1; step(); bus.clear = 0;

    // pause mid-second, resume keeps partial second
    bus.mode_sel_en = 0; bus.limit_min = 6'd3; bus.start = 1;
    step();
    bus.start = 0;
    repeat (4) step();
    bus.stop = 1; step(); bus.stop = 0;
    repeat (50) step();
    chk("paused_sec", 32'(bus.sec), 0);
    bus.start = 1; step(); bus.start = 0;
    cnt = 0;
    while (!bus.tick && cnt < 20) begin step(); cnt++; end
    chk("resume_tick_latency", cnt, 6);

    // clear during RUN at 0:37
    cnt = 0;
    while (bus.sec != 6'd37 && cnt < 600) begin step(); cnt++; end
    chk("reach_0_37", 32'(bus.sec), 37);
    bus.clear = 1; step(); bus.clear = 0;
    chk("clear_run_running", 32'(bus.running), 0);
    chk("clear_run_sec", 32'(bus.sec), 0);

    // limit 0 -> straight to DONE
    bus.limit_min = 6'd0; bus.start = 1; step(); bus.start = 0;
    chk("zero_limit_done", 32'(bus.done), 1);
    chk("zero_limit_tick", 32'(bus.tick), 0);
    repeat (12) step();
    bus.clear = 1; step(); bus.clear = 0;

    // start+stop together in IDLE
    bus.limit_min = 6'd2; bus.start = 1; bus.stop = 1;
    repeat (3) step();
    bus.start = 0; bus.stop = 0;
    chk("start_stop_idle", 32'(bus.running), 0);

    // async reset between edges mid-run
    bus.start = 1; step(); bus.start = 0;
    repeat (23) step();
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.clear       = ($urandom_range(0, 199) == 0);
      bus.stop        = ($urandom_range(0, 29) == 0);
      bus.start       = ($urandom_range(0, 9) == 0);
      bus.mode_sel_en = $urandom_range(0, 1);
      bus.mode_down   = $urandom_range(0, 1);
      bus.limit_min   = MIN_W'($urandom_range(0, 2));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
